seg_scan_ctrl: RTL

// - Parametrised time-multiplexed seven-segment display driver. Successor to the fixed 4-digit

---
 rtl/seg_scan_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner for common-anode displays.
// Shadowed hex word, per-digit dp, leading-zero blanking, display enable.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int IDX_W       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic                    disp_en,
  output logic [7:0]              segment_data,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    scan_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [PW-1:0]           presc;
  logic [IDX_W-1:0]        idx;

  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank;
  logic                  zero_hi;
  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            seg_next;

  function automatic logic [6:0] hex_dec(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // zero_hi accumulates "this nibble and all above are zero" top-down
  always_comb begin
    nib     = 4'h0;
    dp_sel  = 1'b0;
    blank   = 1'b0;
    zero_hi = 1'b1;
    an_next = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_hi = zero_hi & (shadow_data[4*k +: 4] == 4'h0);
      if (idx == IDX_W'(k)) begin
        nib        = shadow_data[4*k +: 4];
        dp_sel     = shadow_dp[k];
        blank      = lz_blank && (k != 0) && zero_hi;
        an_next[k] = 1'b0;
      end
    end
    seg_next = {~dp_sel, blank ? 7'h7F : hex_dec(nib)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      presc        <= '0;
      idx          <= '0;
      scan_tick    <= 1'b0;
      AN           <= '1;
      segment_data <= 8'hFF;
    end else begin
      scan_tick <= (presc == PRE_LAST);
      if (presc == PRE_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      if (disp_en) begin
        AN           <= an_next;
        segment_data <= seg_next;
      end else begin
        AN           <= '1;
        segment_data <= 8'hFF;
      end
    end
  end

endmodule
